// File: rtl/frame_raster_writer.sv
// frame_raster_writer
//   Generates every pixel write for one 160x120 frame towards the vga_adapter.
//   A frame request snapshots the game-object positions, then the raster is
//   walked row-major at one pixel per clock.  Mid-frame changes to the object
//   inputs therefore cannot tear the image.
//
// Ports
//   clk         system clock
//   resetn      synchronous, active-low reset
//   start       frame request (only honoured while idle)
//   game_over   selects the "dead" dino colour
//   dino_y      dino top row
//   obs1_x/h    obstacle 1 left column / height
//   obs2_x/h    obstacle 2 left column / height
//   x, y        pixel coordinate to vga_adapter
//   colour      pixel colour (0 when not plotting)
//   plot        pixel write enable
//   busy        high while a frame is in progress (including the done cycle)
//   frame_done  one-cycle pulse after the last pixel
module frame_raster_writer #(
  parameter int XMAX       = 159,
  parameter int YMAX       = 119,
  parameter int GROUND_TOP = 105,
  parameter int DINO_LEFT  = 15,
  parameter int DINO_RIGHT = 25,
  parameter int DINO_H     = 12,
  parameter int OBS_W      = 12,
  parameter logic [2:0] COL_BG        = 3'b011,
  parameter logic [2:0] COL_DINO      = 3'b010,
  parameter logic [2:0] COL_DINO_DEAD = 3'b111,
  parameter logic [2:0] COL_OBS1      = 3'b100,
  parameter logic [2:0] COL_OBS2      = 3'b101,
  parameter logic [2:0] COL_GRND      = 3'b110
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       game_over,
  input  logic [7:0] dino_y,
  input  logic [7:0] obs1_x,
  input  logic [7:0] obs1_h,
  input  logic [7:0] obs2_x,
  input  logic [7:0] obs2_h,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done
);

  // Sized copies of the geometry; all bound arithmetic is done in 9 bits so
  // that an obstacle near column 255 is clipped instead of wrapping to 0.
  localparam logic [7:0] X_LAST  = 8'(XMAX);
  localparam logic [6:0] Y_LAST  = 7'(YMAX);
  localparam logic [8:0] GT9     = 9'(GROUND_TOP);
  localparam logic [8:0] DL9     = 9'(DINO_LEFT);
  localparam logic [8:0] DR9     = 9'(DINO_RIGHT);
  localparam logic [8:0] DH9     = 9'(DINO_H);
  localparam logic [8:0] OW9     = 9'(OBS_W);
  localparam logic [7:0] GT8     = 8'(GROUND_TOP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cx_q, cx_d;
  logic [6:0] cy_q, cy_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Frame snapshot
  logic       go_q, go_d;
  logic [7:0] dino_y_q, dino_y_d;
  logic [7:0] obs_x_q [2];
  logic [7:0] obs_x_d [2];
  logic [7:0] obs_h_q [2];
  logic [7:0] obs_h_d [2];

  logic [7:0] obs_x_in [2];
  logic [7:0] obs_h_in [2];

  assign obs_x_in[0] = obs1_x;
  assign obs_x_in[1] = obs2_x;
  assign obs_h_in[0] = obs1_h;
  assign obs_h_in[1] = obs2_h;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cx_q     <= '0;
      cy_q     <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      go_q     <= 1'b0;
      dino_y_q <= '0;
      obs_x_q  <= '{default: '0};
      obs_h_q  <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      go_q     <= go_d;
      dino_y_q <= dino_y_d;
      obs_x_q  <= obs_x_d;
      obs_h_q  <= obs_h_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.  plot/busy/frame_done are registered alongside the state
  // so that they leave the block straight from flops.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    plot_d   = plot_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    go_d     = go_q;
    dino_y_d = dino_y_q;
    obs_x_d  = obs_x_q;
    obs_h_d  = obs_h_q;

    case (state_q)
      IDLE: begin
        plot_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          state_d  = SCAN;
          plot_d   = 1'b1;
          busy_d   = 1'b1;
          cx_d     = '0;
          cy_d     = '0;
          go_d     = game_over;
          dino_y_d = dino_y;
          obs_x_d  = obs_x_in;
          obs_h_d  = obs_h_in;
        end
      end

      SCAN: begin
        if (cx_q == X_LAST) begin
          cx_d = '0;
          if (cy_q == Y_LAST) begin
            // Last pixel emitted; counters return to 0 so x/y read 0 when idle.
            cy_d    = '0;
            state_d = DONE;
            plot_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        plot_d  = 1'b0;
        busy_d  = 1'b0;
        cx_d    = '0;
        cy_d    = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Colour decode: registers only, never the live object inputs.
  // ---------------------------------------------------------------------------
  logic [8:0] cx9, cy9;
  logic [8:0] dino_top9;
  logic       ground_hit, dino_hit;
  logic [1:0] obs_hit;

  assign cx9       = {1'b0, cx_q};
  assign cy9       = {2'b00, cy_q};
  assign dino_top9 = {1'b0, dino_y_q};

  assign ground_hit = (cy9 >= GT9);
  assign dino_hit   = (cx9 >= DL9) && (cx9 < DR9) &&
                      (cy9 >= dino_top9) && (cy9 < dino_top9 + DH9);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_obs
      logic [8:0] left9;
      logic [8:0] top9;
      assign left9 = {1'b0, obs_x_q[gi]};
      // Tall obstacles clamp to the top of the screen rather than underflowing.
      assign top9  = (obs_h_q[gi] >= GT8) ? 9'd0 : (GT9 - {1'b0, obs_h_q[gi]});
      assign obs_hit[gi] = (cx9 >= left9) && (cx9 < left9 + OW9) && (cy9 >= top9);
    end
  endgenerate

  always_comb begin
    colour = 3'b000;
    if (plot_q) begin
      if (ground_hit)      colour = COL_GRND;
      else if (dino_hit)   colour = go_q ? COL_DINO_DEAD : COL_DINO;
      else if (obs_hit[0]) colour = COL_OBS1;
      else if (obs_hit[1]) colour = COL_OBS2;
      else                 colour = COL_BG;
    end
  end

  assign x          = cx_q;
  assign y          = cy_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_frame_raster_writer.sv
// Directed bench for frame_raster_writer: captures each frame into a pixel
// buffer and checks timing, pixel colours, snapshot isolation, clipping,
// back-to-back framing and mid-frame reset.
module tb_frame_raster_writer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       game_over;
  logic [7:0] dino_y, obs1_x, obs1_h, obs2_x, obs2_h;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, frame_done;

  always #5 clk = ~clk;

  frame_raster_writer dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .game_over  (game_over),
    .dino_y     (dino_y),
    .obs1_x     (obs1_x),
    .obs1_h     (obs1_h),
    .obs2_x     (obs2_x),
    .obs2_h     (obs2_h),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [2:0] fb [0:119][0:159];
  int plot_cnt, done_cnt, done_off, first_off, busy_bad, first_cyc, chg_mode;
  logic [7:0] first_x;
  logic [6:0] first_y;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Called with start already driven; the next edge is the sampling edge N.
  // Observes cycles N+1..N+19202 and records every plotted pixel.
  task automatic scan_frame(input bit hold, input bit poke);
    plot_cnt  = 0;
    done_cnt  = 0;
    done_off  = -1;
    first_off = -1;
    busy_bad  = 0;
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++)
        fb[yy][xx] = 3'bxxx;
    step();
    if (!hold) start = 1'b0;
    for (int off = 1; off <= 19202; off++) begin
      if (plot === 1'b1) begin
        plot_cnt++;
        if (first_off < 0) begin
          first_off = off;
          first_cyc = cyc;
          first_x   = x;
          first_y   = y;
        end
        if (x <= 8'd159 && y <= 7'd119) fb[y][x] = colour;
        if (plot_cnt == 1000) begin
          if (chg_mode == 1) dino_y = 8'd50;
          if (chg_mode == 2) begin
            dino_y = 8'd93; obs1_x = 8'd150; obs1_h = 8'd10;
            obs2_x = 8'd250; obs2_h = 8'd20; game_over = 1'b1;
          end
        end
        if (poke) start = (plot_cnt == 3000 || plot_cnt == 3001);
      end
      if (frame_done === 1'b1) begin
        done_cnt++;
        if (done_off < 0) done_off = off;
        if (poke) start = 1'b1;
      end else if (poke && plot !== 1'b1) begin
        start = 1'b0;
      end
      if (busy !== (off <= 19201)) busy_bad++;
      if (off < 19202) step();
    end
  endtask

  initial begin
    int bad, pc, e1, n101;
    resetn = 1'b0; start = 1'b0; game_over = 1'b0;
    dino_y = '0; obs1_x = '0; obs1_h = '0; obs2_x = '0; obs2_h = '0;
    chg_mode = 0;

    // Reset and idle
    repeat (3) step();
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_colour", colour, 0);
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (plot !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Frame A: main colours, snapshot isolation, start pokes in SCAN and DONE
    dino_y = 8'd93; obs1_x = 8'd120; obs1_h = 8'd7; obs2_x = 8'd254; obs2_h = 8'd14;
    chg_mode = 1;
    start = 1'b1;
    scan_frame(1'b0, 1'b1);
    chk("A_plot_cnt", plot_cnt, 19200);
    chk("A_first_off", first_off, 1);
    chk("A_first_x", first_x, 0);
    chk("A_first_y", first_y, 0);
    chk("A_done_off", done_off, 19201);
    chk("A_done_cnt", done_cnt, 1);
    chk("A_busy_bad", busy_bad, 0);
    chk("A_px20_100", fb[100][20], 3'b010);
    chk("A_px125_100", fb[100][125], 3'b100);
    chk("A_px125_97", fb[97][125], 3'b011);
    chk("A_px0_105", fb[105][0], 3'b110);
    chk("A_px159_119", fb[119][159], 3'b110);
    chk("A_px20_60", fb[60][20], 3'b011);
    chk("A_px20_95", fb[95][20], 3'b010);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (busy !== 1'b0 || plot !== 1'b0) bad++;
    end
    chk("A_no_queue", bad, 0);

    // Frame B: start held high; new geometry applied mid-frame must not show
    chg_mode = 2;
    start = 1'b1;
    scan_frame(1'b1, 1'b0);
    e1 = first_cyc;
    chk("B_plot_cnt", plot_cnt, 19200);
    chk("B_done_off", done_off, 19201);
    chk("B_px20_60", fb[60][20], 3'b010);
    chk("B_px125_100", fb[100][125], 3'b100);
    chk("B_px20_100", fb[100][20], 3'b011);

    // Frame C: back-to-back from held start; clipping and dead dino
    chg_mode = 0;
    scan_frame(1'b0, 1'b0);
    chk("C_gap", first_cyc - e1, 19202);
    chk("C_plot_cnt", plot_cnt, 19200);
    chk("C_px159_100", fb[100][159], 3'b100);
    chk("C_px0_100", fb[100][0], 3'b011);
    chk("C_px1_100", fb[100][1], 3'b011);
    chk("C_px20_100", fb[100][20], 3'b111);
    n101 = 0;
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++)
        if (fb[yy][xx] === 3'b101) n101++;
    chk("C_no_obs2", n101, 0);

    // Frame D: reset after 5000 pixels, then a full frame
    game_over = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    pc = 0;
    for (int i = 0; i < 6000 && pc < 5000; i++) begin
      if (plot === 1'b1) pc++;
      if (pc < 5000) step();
    end
    chk("D_pix_reached", pc, 5000);
    resetn = 1'b0;
    step();
    chk("D_rst_plot", plot, 0);
    chk("D_rst_busy", busy, 0);
    chk("D_rst_done", frame_done, 0);
    chk("D_rst_x", x, 0);
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (frame_done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("D_no_done", bad, 0);
    start = 1'b1;
    scan_frame(1'b0, 1'b0);
    chk("E_plot_cnt", plot_cnt, 19200);
    chk("E_first_x", first_x, 0);
    chk("E_first_y", first_y, 0);
    chk("E_done_off", done_off, 19201);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
